// File: rtl/alu_dispatch_if.sv
// Handshake and external-unit bus for alu_dispatch.
// slave = the dispatcher; master = the producer/consumer and the mul/div units.
interface alu_dispatch_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  opcode;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        carry;
   logic        zero;
   logic        err;
   logic        mul_load;
   logic [15:0] mul_m;
   logic [15:0] mul_q;
   logic [31:0] mul_p;
   logic        div_ld;
   logic [15:0] div_dividend;
   logic [15:0] div_divisor;
   logic [15:0] div_q;
   logic [15:0] div_r;

   modport slave (
      input  in_valid, opcode, op_a, op_b, out_ready, mul_p, div_q, div_r,
      output in_ready, out_valid, result, carry, zero, err,
             mul_load, mul_m, mul_q, div_ld, div_dividend, div_divisor
   );

   modport master (
      output in_valid, opcode, op_a, op_b, out_ready, mul_p, div_q, div_r,
      input  in_ready, out_valid, result, carry, zero, err,
             mul_load, mul_m, mul_q, div_ld, div_dividend, div_divisor
   );
endinterface

// File: rtl/alu_dispatch.sv
// 16-bit ALU front-end: simple ops run in one cycle, mul/div are strobed to
// external units and their results sampled after a fixed latency.
module alu_dispatch #(
   parameter int LD_CYCLES = 2,
   parameter int MUL_LAT   = 18,
   parameter int DIV_LAT   = 20
) (
   input  logic          clk,
   input  logic          rst,
   alu_dispatch_if.slave bus
);
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MUL = 3'd5;
   localparam logic [2:0] OP_DIV = 3'd6;
   localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW     = $clog2(MAXLAT + LD_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, EXEC, LOAD, WAIT, DONE} state_e;

   state_e        state_q;
   logic [2:0]    opc_q;
   logic [15:0]   a_q, b_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   result_q;
   logic          carry_q, zero_q, err_q;
   logic          mul_load_q, div_ld_q;

   logic [31:0]   alu_res_d;
   logic          alu_carry_d, alu_err_d;
   logic [16:0]   sum_d;
   logic [31:0]   cap_d;

   always_comb begin
      sum_d       = {1'b0, a_q} + {1'b0, b_q};
      alu_res_d   = '0;
      alu_carry_d = 1'b0;
      alu_err_d   = 1'b0;
      case (opc_q)
         OP_ADD: begin alu_res_d = {15'b0, sum_d}; alu_carry_d = sum_d[16]; end
         OP_SUB: begin alu_res_d = {16'b0, a_q - b_q}; alu_carry_d = (a_q < b_q); end
         OP_AND: alu_res_d = {16'b0, a_q & b_q};
         OP_OR:  alu_res_d = {16'b0, a_q | b_q};
         OP_XOR: alu_res_d = {16'b0, a_q ^ b_q};
         // Only a zero divisor reaches EXEC with a div opcode.
         OP_DIV: begin alu_res_d = {a_q, 16'hFFFF}; alu_err_d = 1'b1; end
         default: alu_err_d = 1'b1;
      endcase
      cap_d = (opc_q == OP_MUL) ? bus.mul_p : {bus.div_r, bus.div_q};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         opc_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         zero_q     <= 1'b0;
         err_q      <= 1'b0;
         mul_load_q <= 1'b0;
         div_ld_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               opc_q <= bus.opcode;
               a_q   <= bus.op_a;
               b_q   <= bus.op_b;
               cnt_q <= '0;
               if (bus.opcode == OP_MUL || (bus.opcode == OP_DIV && bus.op_b != 16'd0))
                  state_q <= LOAD;
               else
                  state_q <= EXEC;
            end
            EXEC: begin
               result_q <= alu_res_d;
               carry_q  <= alu_carry_d;
               err_q    <= alu_err_d;
               zero_q   <= (alu_res_d == 32'd0);
               state_q  <= DONE;
            end
            // First LOAD cycle raises the strobe; it then stays up LD_CYCLES cycles.
            LOAD: if (cnt_q == CW'(LD_CYCLES)) begin
               mul_load_q <= 1'b0;
               div_ld_q   <= 1'b0;
               cnt_q      <= (opc_q == OP_MUL) ? CW'(MUL_LAT - 1) : CW'(DIV_LAT - 1);
               state_q    <= WAIT;
            end else begin
               mul_load_q <= (opc_q == OP_MUL);
               div_ld_q   <= (opc_q == OP_DIV);
               cnt_q      <= cnt_q + CW'(1);
            end
            WAIT: if (cnt_q == '0) begin
               result_q <= cap_d;
               zero_q   <= (cap_d == 32'd0);
               carry_q  <= 1'b0;
               err_q    <= 1'b0;
               state_q  <= DONE;
            end else begin
               cnt_q <= cnt_q - CW'(1);
            end
            DONE: if (bus.out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready     = (state_q == IDLE);
   assign bus.out_valid    = (state_q == DONE);
   assign bus.result       = result_q;
   assign bus.carry        = carry_q;
   assign bus.zero         = zero_q;
   assign bus.err          = err_q;
   assign bus.mul_load     = mul_load_q;
   assign bus.mul_m        = a_q;
   assign bus.mul_q        = b_q;
   assign bus.div_ld       = div_ld_q;
   assign bus.div_dividend = a_q;
   assign bus.div_divisor  = b_q;
endmodule

// File: tb/tb_alu_dispatch.sv
// Random and directed checks of alu_dispatch against an arithmetic reference,
// with behavioural mul/div units that only present valid data after their latency.
module tb_alu_dispatch;
   localparam int LD = 2;
   localparam int ML = 18;
   localparam int DL = 20;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   alu_dispatch_if bus();

   alu_dispatch #(.LD_CYCLES(LD), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   // External units: outputs are garbage until the latency after the strobe has elapsed.
   int          mcnt = 255, dcnt = 255;
   logic [31:0] mprod = '0;
   logic [15:0] dq = '0, dr = '0;
   always @(posedge clk) begin
      if (bus.mul_load) begin
         mcnt  <= 0;
         mprod <= 32'(int'($signed(bus.mul_m)) * int'($signed(bus.mul_q)));
      end else if (mcnt < 255) mcnt <= mcnt + 1;
      if (bus.div_ld) begin
         dcnt <= 0;
         dq   <= (bus.div_divisor == 0) ? 16'hFFFF : bus.div_dividend / bus.div_divisor;
         dr   <= (bus.div_divisor == 0) ? bus.div_dividend : bus.div_dividend % bus.div_divisor;
      end else if (dcnt < 255) dcnt <= dcnt + 1;
   end
   assign bus.mul_p = (mcnt >= ML - 1) ? mprod : 32'hDEADBEEF;
   assign bus.div_q = (dcnt >= DL - 1) ? dq : 16'hBAD0;
   assign bus.div_r = (dcnt >= DL - 1) ? dr : 16'hBAD1;

   // Strobe monitor: cumulative high-cycle counts and operands seen while strobed.
   int          mul_hi = 0, div_hi = 0;
   logic [15:0] m_seen = '0, q_seen = '0, dd_seen = '0, dv_seen = '0;
   always @(posedge clk) begin
      if (bus.mul_load) begin mul_hi++; m_seen = bus.mul_m; q_seen = bus.mul_q; end
      if (bus.div_ld) begin div_hi++; dd_seen = bus.div_dividend; dv_seen = bus.div_divisor; end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [31:0] r, output logic c, output logic e,
                                 output int lat);
      int ua = int'(a);
      int ub = int'(b);
      c = 1'b0; e = 1'b0; lat = 1; r = '0;
      case (op)
         3'd0: begin r = 32'(ua + ub); c = (ua + ub) > 65535; end
         3'd1: begin r = 32'((ua - ub) & 32'hFFFF); c = (ua < ub); end
         3'd2: r = {16'h0, a & b};
         3'd3: r = {16'h0, a | b};
         3'd4: r = {16'h0, a ^ b};
         3'd5: begin r = 32'(int'($signed(a)) * int'($signed(b))); lat = 1 + LD + ML; end
         3'd6: if (b == 0) begin r = {a, 16'hFFFF}; e = 1'b1; end
               else begin r = {16'(ua % ub), 16'(ua / ub)}; lat = 1 + LD + DL; end
         default: begin r = '0; e = 1'b1; end
      endcase
   endfunction

   task automatic start_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      int k = 0;
      while (!bus.in_ready && k < 200) begin @(posedge clk); #1; k++; end
      chk("idle_wait", {31'b0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1; bus.opcode = op; bus.op_a = a; bus.op_b = b;
      @(posedge clk); #1;
      // Operands scrambled after acceptance must not matter.
      bus.in_valid = 1'b0; bus.op_a = 16'($urandom); bus.op_b = 16'($urandom);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int hold);
      logic [31:0] er; logic ec, ee; int el; int lat = 0;
      int mh0 = mul_hi, dh0 = div_hi;
      model(op, a, b, er, ec, ee, el);
      start_op(op, a, b);
      while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("latency", lat, el);
      chk("result", bus.result, er);
      chk("carry", {31'b0, bus.carry}, {31'b0, ec});
      chk("zero", {31'b0, bus.zero}, {31'b0, er == 0});
      chk("err", {31'b0, bus.err}, {31'b0, ee});
      chk("in_ready_busy", {31'b0, bus.in_ready}, 32'd0);
      chk("mul_strobes", mul_hi - mh0, (op == 3'd5) ? LD : 0);
      chk("div_strobes", div_hi - dh0, (op == 3'd6 && b != 0) ? LD : 0);
      if (op == 3'd5) begin
         chk("mul_m", {16'b0, m_seen}, {16'b0, a});
         chk("mul_q", {16'b0, q_seen}, {16'b0, b});
      end
      if (op == 3'd6 && b != 0) begin
         chk("div_dividend", {16'b0, dd_seen}, {16'b0, a});
         chk("div_divisor", {16'b0, dv_seen}, {16'b0, b});
      end
      // Backpressure: a competing request is offered and must be ignored.
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1; bus.opcode = 3'($urandom); bus.op_a = 16'($urandom);
         @(posedge clk); #1;
         chk("hold_stable", {bus.out_valid, bus.in_ready, bus.carry, bus.zero, bus.err},
             {1'b1, 1'b0, ec, er == 0, ee});
         chk("hold_result", bus.result, er);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("handshake", {30'b0, bus.out_valid, bus.in_ready}, 32'b01);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.opcode = '0; bus.op_a = '0; bus.op_b = '0; bus.out_ready = 1'b0;
      #12;
      chk("rst_state", {bus.in_ready, bus.out_valid, bus.carry, bus.zero, bus.err,
                        bus.mul_load, bus.div_ld}, 32'b1000000);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_operands", {bus.mul_m, bus.div_divisor}, 32'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      run_op(3'd0, 16'd7, 16'd3, 0);
      run_op(3'd0, 16'hFFFF, 16'd1, 0);
      run_op(3'd1, 16'd5, 16'd7, 0);
      run_op(3'd4, 16'd23, 16'd23, 0);
      run_op(3'd5, 16'd931, 16'd788, 0);
      run_op(3'd5, 16'hFFFD, 16'd1000, 1);
      run_op(3'd6, 16'd3473, 16'd147, 0);
      run_op(3'd6, 16'd100, 16'd0, 0);
      run_op(3'd2, 16'hF0F0, 16'h3C3C, 10);

      // Reset in the middle of a divide's wait phase.
      start_op(3'd6, 16'd5000, 16'd7);
      repeat (8) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrst", {29'b0, bus.out_valid, bus.in_ready, bus.div_ld}, 32'b010);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      run_op(3'd7, 16'h1234, 16'h5678, 0);

      for (int n = 0; n < 30; n++) begin
         logic [2:0] op = 3'($urandom);
         logic [15:0] a = 16'($urandom);
         logic [15:0] b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         run_op(op, a, b, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- Operation front-end and sequencer for the 16-bit ALU. Accepts one opcode plus two operands per transaction over a valid/ready handshake.
- Add, sub, and, or and xor are executed internally in one cycle.
- Multiply and divide are dispatched to the downstream booth multiplier and restoring divider. Those units have no done signal, so the block pulses their load inputs, counts a fixed latency, then captures the result.
- Results are held on a valid/ready output port until consumed.

Parameters:
- LD_CYCLES, 2: cycles that mul_load/div_ld stay high per dispatch (1..4).
- MUL_LAT, 18: cycles waited after load deassertion before sampling mul_p.
- DIV_LAT, 20: cycles waited after load deassertion before sampling div_q/div_r.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  opcode/operands valid.
- in_ready  out  1  block can accept a transaction.
- opcode  in  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110 div, 111 reserved.
- op_a  in  16  operand A; dividend for div; multiplicand (M) for mul.
- op_b  in  16  operand B; divisor for div; multiplier (Q) for mul.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  32  result word.
- carry  out  1  add carry-out / sub borrow.
- zero  out  1  result == 0.
- err  out  1  div by zero or reserved opcode.
- mul_load  out  1  load strobe to booth multiplier.
- mul_m  out  16  multiplier M operand.
- mul_q  out  16  multiplier Q operand.
- mul_p  in  32  multiplier product.
- div_ld  out  1  load strobe to divider.
- div_dividend  out  16  dividend to divider.
- div_divisor  out  16  divisor to divider.
- div_q  in  16  divider quotient.
- div_r  in  16  divider remainder.

Behaviour:
- Reset (rst low, async):
  - State goes to IDLE.
  - in_ready=1; out_valid=0; result=0; carry=0; zero=0; err=0.
  - mul_load=0; div_ld=0; operand registers=0; latency counter=0.
  - Reset deasserts synchronously to internal logic. Reset mid-dispatch abandons the operation; the external units are not reset by this block, and their stale outputs are ignored.
- States: IDLE, EXEC, LOAD, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, register opcode/op_a/op_b.
  - Opcodes 000-100, 111, and div with op_b==0 go to EXEC.
  - Mul and div with op_b!=0 go to LOAD.
- EXEC: one cycle. Compute and register result and flags, then go to DONE. out_valid rises on the edge after acceptance + 1.
  - add: result={15'b0,cout,sum}; carry=cout.
  - sub: result={16'b0,(A-B)[15:0]}; carry=1 when A<B (unsigned).
  - and/or/xor: result={16'b0,A op B}; carry=0.
  - div by zero: result={op_a, 16'hFFFF} (remainder=dividend, quotient=all ones); err=1.
  - reserved: result=0; err=1.
- LOAD:
  - mul_m/mul_q (or div_dividend/div_divisor) driven from the registered operands for the whole transaction, from LOAD through DONE.
  - Strobe (mul_load or div_ld) high for exactly LD_CYCLES cycles; the strobe of the unused unit stays 0.
  - Go to WAIT with the counter loaded to MUL_LAT-1 or DIV_LAT-1.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where the counter==0, capture: mul: result=mul_p; div: result={div_r, div_q}.
  - carry=0, err=0. Go to DONE.
- Latency from acceptance edge to out_valid:
  - ALU ops: 1 edge.
  - Mul: 1+LD_CYCLES+MUL_LAT edges.
  - Div: 1+LD_CYCLES+DIV_LAT edges.
- zero: computed on the full 32-bit captured result in every path.
- DONE:
  - out_valid=1; result and flags held stable.
  - On an edge with out_ready=1, out_valid goes to 0 and state goes to IDLE.
  - in_ready=0 in every state except IDLE. There is no overlap of transactions, so acceptance and completion can never be simultaneous.
- in_valid or operand changes outside IDLE are ignored.
- Outputs are registered; no combinational path from in_valid/out_ready to outputs other than none. in_ready and out_valid are state decodes.

Test Plan:
- add 7+3, out_ready=1 -> out_valid 2nd edge after accept; result=10, carry=0, zero=0. Then add 0xFFFF+1 -> result=0x10000, carry=1, zero=0.
- sub 5-7 -> result=0x0000FFFE, carry=1. Then xor 23^23 -> result=0, zero=1.
- mul 931x788 with a behavioural booth model -> mul_load high exactly 2 cycles, mul_m=931, mul_q=788; result=733628 after 21 edges.
- div 3473/147 -> div_ld high 2 cycles; result={16'd92,16'd23}, err=0, latency 23 edges. div 100/0 -> div_ld never asserts; result=0x0064FFFF, err=1.
- Backpressure: out_ready low 10 cycles after a result -> out_valid, result and flags stable; in_ready=0; a new in_valid is ignored until the handshake completes.
- Reset: rst low during WAIT of a div -> immediately out_valid=0, in_ready=1, div_ld=0. After release, opcode 111 -> err=1, result=0.
